// File: rtl/dual_rail_rx.sv
// Complementary-pair (p/q) link receiver: decodes bits, assembles LSB-first words, one-entry output buffer.
// Optional per-word even parity bit enabled by defining DUAL_RAIL_PARITY_EN.
module dual_rail_rx #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             p,
   input  logic             q,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   input  logic             data_ready,
   output logic             err_illegal,
   output logic             overflow,
`ifdef DUAL_RAIL_PARITY_EN
   output logic             parity_err,
`endif
   output logic [CNT_W-1:0] err_count
);

`ifdef DUAL_RAIL_PARITY_EN
   localparam int FRAME = WIDTH + 1;
`else
   localparam int FRAME = WIDTH;
`endif
   localparam int BC_W  = $clog2(FRAME + 1);
   localparam int IDX_W = $clog2(WIDTH);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   logic             r_sp_p1, r_sq_p1;
   logic [BC_W-1:0]  r_bit_cnt;
   logic [WIDTH-1:0] r_shift;
   logic [WIDTH-1:0] r_data;
   logic             r_valid;
   logic             r_err_illegal;
   logic             r_overflow;
   logic [CNT_W-1:0] r_err_count;

   logic             w_bit_vld, w_bit, w_illegal, w_last;
   logic             w_word_ok, w_par_bad, w_load, w_drop, w_err;
   logic [IDX_W-1:0] w_idx;
   logic [WIDTH-1:0] w_shift_nxt;

   // Stage 1: raw p/q capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sp_p1 <= 1'b0;
         r_sq_p1 <= 1'b0;
      end else begin
         r_sp_p1 <= p;
         r_sq_p1 <= q;
      end
   end

   // Stage 2: decode {sp,sq}; 10 = one, 01 = zero, 00 = idle, 11 = illegal
   assign w_bit_vld = r_sp_p1 ^ r_sq_p1;
   assign w_bit     = r_sp_p1;
   assign w_illegal = r_sp_p1 & r_sq_p1;
   assign w_last    = w_bit_vld && (r_bit_cnt == BC_W'(FRAME - 1));
   assign w_idx     = r_bit_cnt[IDX_W-1:0];

   always_comb begin
      w_shift_nxt = r_shift;
      if (w_bit_vld && (r_bit_cnt < BC_W'(WIDTH)))
         w_shift_nxt[w_idx] = w_bit;
   end

`ifdef DUAL_RAIL_PARITY_EN
   // The final frame bit is even parity over the data bits already in r_shift
   assign w_word_ok = w_last && ((^r_shift) == w_bit);
   assign w_par_bad = w_last && ((^r_shift) != w_bit);
`else
   assign w_word_ok = w_last;
   assign w_par_bad = 1'b0;
`endif

   assign w_load = w_word_ok & (~r_valid | data_ready);
   assign w_drop = w_word_ok & r_valid & ~data_ready;
   assign w_err  = w_illegal | w_drop | w_par_bad;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bit_cnt <= '0;
         r_shift   <= '0;
      end else begin
         r_shift <= w_shift_nxt;
         if (w_bit_vld && !w_last)
            r_bit_cnt <= r_bit_cnt + BC_W'(1);
         else
            r_bit_cnt <= '0;
      end
   end

   // Stage 3: holding register and error reporting
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data        <= '0;
         r_valid       <= 1'b0;
         r_err_illegal <= 1'b0;
         r_overflow    <= 1'b0;
         r_err_count   <= '0;
      end else begin
         if (w_load)
            r_data <= w_shift_nxt;
         r_valid       <= w_load | (r_valid & ~data_ready);
         r_err_illegal <= w_illegal;
         r_overflow    <= w_drop;
         if (w_err)
            r_err_count <= sat_inc(r_err_count);
      end
   end

`ifdef DUAL_RAIL_PARITY_EN
   logic r_parity_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_parity_err <= 1'b0;
      else     r_parity_err <= w_par_bad;
   end

   assign parity_err = r_parity_err;
`endif

   assign data_out    = r_data;
   assign data_valid  = r_valid;
   assign err_illegal = r_err_illegal;
   assign overflow    = r_overflow;
   assign err_count   = r_err_count;

endmodule

// File: tb/tb_dual_rail_rx.sv
// Directed self-checking bench for dual_rail_rx (WIDTH=8); a second instance with CNT_W=2 shares the inputs.
module tb_dual_rail_rx;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             p = 1'b0;
   logic             q = 1'b0;
   logic             data_ready = 1'b0;
   logic [WIDTH-1:0] data_out, data_out2;
   logic             data_valid, data_valid2;
   logic             err_illegal, err_illegal2;
   logic             overflow, overflow2;
   logic [7:0]       err_count;
   logic [1:0]       err_count2;
`ifdef DUAL_RAIL_PARITY_EN
   logic             parity_err, parity_err2;
`endif

   int n_chk  = 0;
   int n_pass = 0;
   int n_hs   = 0;
   int n_ill  = 0;
   int n_ovf  = 0;
   logic [WIDTH-1:0] last_word = '0;

   always #5 clk = ~clk;

   dual_rail_rx #(.WIDTH(WIDTH), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .p(p), .q(q),
      .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
      .err_illegal(err_illegal), .overflow(overflow),
`ifdef DUAL_RAIL_PARITY_EN
      .parity_err(parity_err),
`endif
      .err_count(err_count)
   );

   dual_rail_rx #(.WIDTH(WIDTH), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .p(p), .q(q),
      .data_out(data_out2), .data_valid(data_valid2), .data_ready(data_ready),
      .err_illegal(err_illegal2), .overflow(overflow2),
`ifdef DUAL_RAIL_PARITY_EN
      .parity_err(parity_err2),
`endif
      .err_count(err_count2)
   );

   // Event log of the main instance: accepted words and error pulses
   always @(posedge clk) begin
      if (data_valid && data_ready) begin
         n_hs      <= n_hs + 1;
         last_word <= data_out;
      end
      if (err_illegal) n_ill <= n_ill + 1;
      if (overflow)    n_ovf <= n_ovf + 1;
   end

   task automatic send_sym(input logic a, input logic b);
      p = a;
      q = b;
      @(posedge clk);
      #1;
   endtask

   task automatic send_bits(input logic [WIDTH-1:0] w, input int n);
      for (int i = 0; i < n; i++) send_sym(w[i], ~w[i]);
   endtask

   task automatic send_word(input logic [WIDTH-1:0] w);
      send_bits(w, WIDTH);
`ifdef DUAL_RAIL_PARITY_EN
      send_sym(^w, ~(^w));
`endif
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) send_sym(1'b0, 1'b0);
   endtask

   task automatic do_reset();
      p = 1'b0;
      q = 1'b0;
      rst = 1'b1;
      #2;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      p = 1'b0;
      q = 1'b0;
      rst = 1'b1;
      #2;
      n_chk++;
      if ({data_valid, err_illegal, overflow, data_out, err_count} !== '0)
         $display("FAIL reset_outputs: got v=%b ill=%b ovf=%b d=%h cnt=%0d, want all 0",
                  data_valid, err_illegal, overflow, data_out, err_count);
      else n_pass++;
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(2);
      n_chk++;
      if ({data_valid, err_count} !== '0)
         $display("FAIL reset_idle: got v=%b cnt=%0d, want 0 0", data_valid, err_count);
      else n_pass++;
   endtask

   task automatic test_single_word();
      int hs0;
      do_reset();
      data_ready = 1'b1;
      hs0 = n_hs;
      send_word(8'hA5);
      n_chk++;
      if (data_valid !== 1'b0)
         $display("FAIL a5_early: data_valid=%b one cycle after last bit, want 0", data_valid);
      else n_pass++;
      idle(1);
      n_chk++;
      if (data_valid !== 1'b1 || data_out !== 8'hA5)
         $display("FAIL a5_word: got v=%b d=%h, want v=1 d=a5", data_valid, data_out);
      else n_pass++;
      idle(1);
      n_chk++;
      if (data_valid !== 1'b0 || (n_hs - hs0) !== 1 || err_count !== 8'd0)
         $display("FAIL a5_consumed: got v=%b hs=%0d cnt=%0d, want v=0 hs=1 cnt=0",
                  data_valid, n_hs - hs0, err_count);
      else n_pass++;
   endtask

   task automatic test_overflow();
      int hs0, ovf0;
      do_reset();
      data_ready = 1'b0;
      hs0  = n_hs;
      ovf0 = n_ovf;
      send_word(8'h3C);
      send_word(8'hFF);
      idle(1);
      n_chk++;
      if (overflow !== 1'b1 || err_count !== 8'd1 || data_out !== 8'h3C || data_valid !== 1'b1)
         $display("FAIL ovf_pulse: got ovf=%b cnt=%0d d=%h v=%b, want 1 1 3c 1",
                  overflow, err_count, data_out, data_valid);
      else n_pass++;
      idle(1);
      n_chk++;
      if (overflow !== 1'b0 || data_out !== 8'h3C || data_valid !== 1'b1)
         $display("FAIL ovf_hold: got ovf=%b d=%h v=%b, want 0 3c 1", overflow, data_out, data_valid);
      else n_pass++;
      data_ready = 1'b1;
      idle(1);
      n_chk++;
      if (data_valid !== 1'b0 || (n_hs - hs0) !== 1 || last_word !== 8'h3C || (n_ovf - ovf0) !== 1)
         $display("FAIL ovf_drain: got v=%b hs=%0d word=%h ovf=%0d, want 0 1 3c 1",
                  data_valid, n_hs - hs0, last_word, n_ovf - ovf0);
      else n_pass++;
   endtask

   task automatic test_idle_abort();
      int hs0;
      do_reset();
      data_ready = 1'b1;
      hs0 = n_hs;
      send_bits(8'h05, 3);
      idle(1);
      send_word(8'h81);
      idle(2);
      n_chk++;
      if ((n_hs - hs0) !== 1 || last_word !== 8'h81 || err_count !== 8'd0)
         $display("FAIL idle_abort: got hs=%0d word=%h cnt=%0d, want 1 81 0",
                  n_hs - hs0, last_word, err_count);
      else n_pass++;
   endtask

   task automatic test_illegal();
      int hs0, ill0;
      do_reset();
      data_ready = 1'b1;
      hs0  = n_hs;
      ill0 = n_ill;
      send_bits(8'h0F, 4);
      send_sym(1'b1, 1'b1);
      send_sym(1'b0, 1'b1);
      n_chk++;
      if (err_illegal !== 1'b1 || overflow !== 1'b0)
         $display("FAIL ill_pulse: got ill=%b ovf=%b, want 1 0", err_illegal, overflow);
      else n_pass++;
      send_bits(8'h12 >> 1, WIDTH - 1);
`ifdef DUAL_RAIL_PARITY_EN
      send_sym(1'b0, 1'b1);
`endif
      idle(2);
      n_chk++;
      if ((n_ill - ill0) !== 1 || err_count !== 8'd1 || (n_hs - hs0) !== 1 || last_word !== 8'h12)
         $display("FAIL ill_word: got ill=%0d cnt=%0d hs=%0d word=%h, want 1 1 1 12",
                  n_ill - ill0, err_count, n_hs - hs0, last_word);
      else n_pass++;
   endtask

   task automatic test_saturation();
      logic [1:0] exp2;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         send_sym(1'b1, 1'b1);
         idle(1);
         exp2 = (k >= 2) ? 2'd3 : 2'(k + 1);
         n_chk++;
         if (err_count2 !== exp2 || err_count !== 8'(k + 1))
            $display("FAIL sat_%0d: got cnt2=%0d cnt=%0d, want %0d %0d",
                     k, err_count2, err_count, exp2, k + 1);
         else n_pass++;
      end
   endtask

   task automatic test_reset_midword();
      int hs0;
      do_reset();
      data_ready = 1'b0;
      send_word(8'h55);
      send_sym(1'b1, 1'b1);
      idle(2);
      n_chk++;
      if (data_valid !== 1'b1 || data_out !== 8'h55 || err_count !== 8'd1)
         $display("FAIL pre_rst: got v=%b d=%h cnt=%0d, want 1 55 1", data_valid, data_out, err_count);
      else n_pass++;
      send_bits(8'h07, 3);
      #2;
      rst = 1'b1;
      #1;
      n_chk++;
      if ({data_valid, err_illegal, overflow, data_out, err_count} !== '0)
         $display("FAIL async_rst: got v=%b ill=%b ovf=%b d=%h cnt=%0d, want all 0",
                  data_valid, err_illegal, overflow, data_out, err_count);
      else n_pass++;
      @(posedge clk);
      #1;
      rst = 1'b0;
      data_ready = 1'b1;
      hs0 = n_hs;
      send_word(8'h6B);
      idle(2);
      n_chk++;
      if ((n_hs - hs0) !== 1 || last_word !== 8'h6B || err_count !== 8'd0)
         $display("FAIL post_rst: got hs=%0d word=%h cnt=%0d, want 1 6b 0",
                  n_hs - hs0, last_word, err_count);
      else n_pass++;
   endtask

`ifdef DUAL_RAIL_PARITY_EN
   task automatic test_parity();
      int hs0;
      do_reset();
      data_ready = 1'b1;
      hs0 = n_hs;
      send_bits(8'h07, WIDTH);
      send_sym(1'b0, 1'b1);
      idle(1);
      n_chk++;
      if (parity_err !== 1'b1 || err_count !== 8'd1 || data_valid !== 1'b0)
         $display("FAIL par_bad: got perr=%b cnt=%0d v=%b, want 1 1 0", parity_err, err_count, data_valid);
      else n_pass++;
      idle(1);
      n_chk++;
      if (parity_err !== 1'b0 || (n_hs - hs0) !== 0)
         $display("FAIL par_after: got perr=%b hs=%0d, want 0 0", parity_err, n_hs - hs0);
      else n_pass++;
   endtask
`endif

   initial begin
      #1;
      test_reset();
      test_single_word();
      test_overflow();
      test_idle_abort();
      test_illegal();
      test_saturation();
      test_reset_midword();
`ifdef DUAL_RAIL_PARITY_EN
      test_parity();
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/dual_rail_rx.md
Name: dual_rail_rx

Overview:
Receiving end of the complementary-pair (p/q) link, where the sender drives p = a and q = ~a from registers cleared to 0.
- Decodes each p/q sample into a data bit, idle, or illegal code.
- Assembles decoded bits LSB-first into WIDTH-bit words.
- Presents each word on a valid/ready output port and counts link errors.
- Sits between the pad-side p/q pair and the consuming datapath.

Parameters:
WIDTH, 8, data bits per word (≥2)
CNT_W, 8, width of the saturating error counter

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  asynchronous active-high reset
p  input  1  true rail from sender
q  input  1  complement rail from sender
data_out  output  WIDTH  assembled word, bit 0 = first bit received
data_valid  output  1  data_out holds an unconsumed word
data_ready  input  1  consumer accepts word when data_valid & data_ready
err_illegal  output  1  one-cycle pulse: p=q=1 sampled
overflow  output  1  one-cycle pulse: completed word dropped, holding register full
err_count  output  CNT_W  saturating count of illegal codes plus dropped words

Behaviour:
- Reset: rst asserted clears all state immediately; removal is synchronous to clk.
  - Registered sample, bit counter, shift register, data_out: all 0.
  - data_valid, err_illegal, overflow, err_count: all 0.
  - Reset mid-word discards the partial word; reset with data_valid=1 discards the held word.
- Stage 1: p/q captured into sample register {sp,sq} every cycle.
- Stage 2 decodes {sp,sq} each cycle:
  - 10 → bit 1
  - 01 → bit 0
  - 00 → idle: partial word aborted, bit counter → 0, no error
  - 11 → illegal: partial word aborted, bit counter → 0, err_illegal pulses next cycle, error counted
- Data bit handling: shifted into position bit_cnt; bit_cnt increments.
  - On the WIDTH-th bit the word completes and bit_cnt → 0.
  - Back-to-back words need no idle between them.
- Latency: last bit of a word on p/q before edge N is sampled at N, decoded at N+1. data_valid=1 and data_out valid after edge N+1 (2 cycles).
- Holding register, one entry:
  - Handshake fires on data_valid & data_ready; data_valid clears next edge unless a new word loads that same edge.
  - Word completes while data_valid=0, or while the handshake fires in the same cycle: word loads, data_valid=1, no overflow.
  - Word completes while data_valid=1 and data_ready=0: new word dropped, held word unchanged, overflow pulses, error counted.
- data_out and data_valid are stable while data_valid=1 and data_ready=0.
- err_count:
  - Increments by 1 per illegal code and per dropped word.
  - Illegal and drop cannot coincide, since an illegal code never completes a word.
  - Saturates at 2^CNT_W−1; no wrap.
- err_illegal and overflow are registered one-cycle pulses, never asserted together.

Optional Feature:
- Macro DUAL_RAIL_PARITY_EN.
- Defined:
  - Each word is followed by one extra bit (WIDTH+1 bits per frame) carrying even parity over the data bits.
  - On a match the word loads as above. On a mismatch the word is discarded, extra output parity_err pulses one cycle, and err_count increments (saturating).
  - Completion latency still counts from the parity bit.
- Not defined: no parity bit, no parity_err port, frames are WIDTH bits.

Test Plan:
- WIDTH=8, data_ready=1: send 0xA5 LSB-first as 10,01,10,01,01,10,01,10 → data_valid high one cycle, 2 cycles after last bit, with data_out=0xA5; err_count=0.
- data_ready=0: send 0x3C then 0xFF back-to-back → data_out stays 0x3C, overflow pulses once, err_count=1; raise data_ready → 0x3C consumed, data_valid=0.
- Send 3 bits, then 00, then full 0x81 → only 0x81 delivered, no error.
- Send 4 bits, then 11, then 0x12 → err_illegal pulses once, err_count=1, only 0x12 delivered.
- CNT_W=2: inject 5 illegal codes → err_count 1,2,3,3,3.
- Assert rst mid-word and with data_valid=1 → all outputs 0 immediately; next full word decoded correctly. With DUAL_RAIL_PARITY_EN: 0x07 with parity bit 0 → parity_err pulse, no word.
